// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator: one request at a time, misaligned halves/words
// split into byte beats, load data reassembled and sign/zero-extended.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_data_in,
    output logic                  mem_read_write,
    output logic [1:0]            mem_access_size,
    output logic                  mem_is_signed,
    input  logic [31:0]           mem_data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    state_t                state, state_next;
    logic [1:0]            beat_p1, beat_next;
    logic [31:0]           rdata_p1, rdata_next;
    logic                  write_p0;
    logic                  unsigned_p0;
    logic [1:0]            size_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [31:0]           wdata_p0;
    logic                  accept;
    logic                  split;
    logic [1:0]            last_idx;
    logic                  last_beat;
    logic [4:0]            lane;

    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        zext);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic [31:0]        result;
        byte_s = raw[7:0];
        half_s = raw[15:0];
        result = raw;
        case (size)
            SIZE_BYTE: result = zext ? {24'b0, raw[7:0]}  : 32'(byte_s);
            SIZE_HALF: result = zext ? {16'b0, raw[15:0]} : 32'(half_s);
            default:   result = raw;
        endcase
        return result;
    endfunction

    assign req_ready  = (state == IDLE) && !reset;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP) && !reset;
    assign resp_error = resp_valid && (size_p0 == SIZE_BAD);
    assign resp_rdata = (resp_valid && !write_p0 && (size_p0 != SIZE_BAD)) ? rdata_p1 : 32'b0;

    assign split     = ((size_p0 == SIZE_HALF) && addr_p0[0]) ||
                       ((size_p0 == SIZE_WORD) && (addr_p0[1:0] != 2'b00));
    assign last_idx  = !split ? 2'd0 : ((size_p0 == SIZE_HALF) ? 2'd1 : 2'd3);
    assign last_beat = (beat_p1 == last_idx);
    assign lane      = {beat_p1, 3'b000};

    always_comb begin
        state_next      = state;
        beat_next       = beat_p1;
        rdata_next      = rdata_p1;
        mem_address     = '0;
        mem_data_in     = 32'b0;
        mem_read_write  = 1'b0;
        mem_access_size = SIZE_WORD;
        mem_is_signed   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    beat_next  = 2'd0;
                    rdata_next = 32'b0;
                    state_next = (req_size == SIZE_BAD) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_read_write = write_p0;
                if (split) begin
                    mem_address                 = addr_p0 + ADDR_WIDTH'(beat_p1);
                    mem_access_size             = SIZE_BYTE;
                    mem_is_signed               = 1'b0;
                    mem_data_in                 = {24'b0, wdata_p0[lane +: 8]};
                    rdata_next[lane +: 8]       = mem_data_out[7:0];
                end else begin
                    mem_address     = addr_p0;
                    mem_access_size = size_p0;
                    mem_is_signed   = ~unsigned_p0;
                    mem_data_in     = wdata_p0;
                    rdata_next      = mem_data_out;
                end
                beat_next = beat_p1 + 2'd1;
                // Extension happens once the final byte lane is in place.
                if (last_beat) begin
                    state_next = RESP;
                    rdata_next = extend_load(rdata_next, size_p0, unsigned_p0);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            beat_p1  <= 2'd0;
            rdata_p1 <= 32'b0;
        end else begin
            state    <= state_next;
            beat_p1  <= beat_next;
            rdata_p1 <= rdata_next;
        end
    end

    // Request capture: fields held for the whole transaction.
    always_ff @(posedge clock) begin
        if (accept) begin
            write_p0    <= req_write;
            size_p0     <= req_size;
            unsigned_p0 <= req_unsigned;
            addr_p0     <= req_addr;
            wdata_p0    <= req_wdata;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed memory model.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read_write;
    logic [1:0]  mem_access_size;
    logic        mem_is_signed;
    logic [31:0] mem_data_out;

    always #5 clock = ~clock;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_error      (resp_error),
        .mem_address     (mem_address),
        .mem_data_in     (mem_data_in),
        .mem_read_write  (mem_read_write),
        .mem_access_size (mem_access_size),
        .mem_is_signed   (mem_is_signed),
        .mem_data_out    (mem_data_out)
    );

    logic [7:0]  mem [256] = '{default: 8'h00};
    logic [7:0]  ra0, ra1, ra2, ra3;
    int          wr_count = 0;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];
    logic [1:0]  wr_size [16];

    assign ra0 = mem_address[7:0];
    assign ra1 = ra0 + 8'd1;
    assign ra2 = ra0 + 8'd2;
    assign ra3 = ra0 + 8'd3;

    always_comb begin
        mem_data_out = 32'h0;
        case (mem_access_size)
            2'b00:   mem_data_out = {{24{mem_is_signed & mem[ra0][7]}}, mem[ra0]};
            2'b01:   mem_data_out = {{16{mem_is_signed & mem[ra1][7]}}, mem[ra1], mem[ra0]};
            default: mem_data_out = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};
        endcase
    end

    always @(posedge clock) begin
        if (mem_read_write) begin
            mem[ra0] = mem_data_in[7:0];
            if (mem_access_size != 2'b00) mem[ra1] = mem_data_in[15:8];
            if (mem_access_size == 2'b10) begin
                mem[ra2] = mem_data_in[23:16];
                mem[ra3] = mem_data_in[31:24];
            end
            wr_addr[wr_count[3:0]] = mem_address;
            wr_data[wr_count[3:0]] = mem_data_in;
            wr_size[wr_count[3:0]] = mem_access_size;
            wr_count = wr_count + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic err,
                         output int nwr, output int base);
        @(negedge clock);
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        base = wr_count;
        @(posedge clock);
        #1;
        req_valid = 1'b0; req_write = ~wr; req_size = 2'b10; req_unsigned = ~uns;
        req_addr = 32'hFFFF_FFF0; req_wdata = 32'h5A5A_5A5A;
        lat = -1; rd = 32'hX; err = 1'bX;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (resp_valid) begin
                lat = c; rd = resp_rdata; err = resp_error;
                break;
            end
        end
        nwr = wr_count - base;
        if (lat > 0) begin
            @(negedge clock);
            check("resp_single_pulse", 32'(resp_valid), 32'd0);
            check("ready_after_resp", 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        int          lat, nwr, base;
        logic [31:0] rd;
        logic        err;
        bit          seen;

        repeat (2) @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_mem_rw", 32'(mem_read_write), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(req_ready), 32'd1);
        check("idle_mem_addr", mem_address, 32'd0);
        check("idle_mem_size", 32'(mem_access_size), 32'd2);

        // Aligned word store then load.
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, err, nwr, base);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_nwr", 32'(nwr), 32'd1);
        check("sw_addr", wr_addr[4'(base)], 32'h10);
        check("sw_data", wr_data[4'(base)], 32'hDEAD_BEEF);
        check("sw_size", 32'(wr_size[4'(base)]), 32'd2);
        check("sw_rdata", rd, 32'd0);
        check("sw_err", 32'(err), 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, err, nwr, base);
        check("lw_lat", 32'(lat), 32'd2);
        check("lw_rdata", rd, 32'hDEAD_BEEF);
        check("lw_nwr", 32'(nwr), 32'd0);

        // Byte loads, signed and unsigned.
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, err, nwr, base);
        check("lb_lat", 32'(lat), 32'd2);
        check("lb_rdata", rd, 32'hFFFF_FFDE);
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, err, nwr, base);
        check("lbu_rdata", rd, 32'h0000_00DE);

        // Misaligned word store split into four byte writes, then load back.
        issue(1'b1, 2'b10, 1'b0, 32'h21, 32'h1122_3344, lat, rd, err, nwr, base);
        check("msw_lat", 32'(lat), 32'd5);
        check("msw_nwr", 32'(nwr), 32'd4);
        check("msw_a0", wr_addr[4'(base)],     32'h21);
        check("msw_d0", wr_data[4'(base)],     32'h44);
        check("msw_a1", wr_addr[4'(base + 1)], 32'h22);
        check("msw_d1", wr_data[4'(base + 1)], 32'h33);
        check("msw_a2", wr_addr[4'(base + 2)], 32'h23);
        check("msw_d2", wr_data[4'(base + 2)], 32'h22);
        check("msw_a3", wr_addr[4'(base + 3)], 32'h24);
        check("msw_d3", wr_data[4'(base + 3)], 32'h11);
        check("msw_size", 32'(wr_size[4'(base + 3)]), 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, lat, rd, err, nwr, base);
        check("mlw_lat", 32'(lat), 32'd5);
        check("mlw_rdata", rd, 32'h1122_3344);

        // Byte stores, then misaligned half loads.
        issue(1'b1, 2'b00, 1'b0, 32'h41, 32'h0000_0034, lat, rd, err, nwr, base);
        check("sb0_lat", 32'(lat), 32'd2);
        issue(1'b1, 2'b00, 1'b0, 32'h42, 32'h0000_0092, lat, rd, err, nwr, base);
        check("sb1_data", wr_data[4'(base)], 32'h92);
        issue(1'b0, 2'b01, 1'b0, 32'h41, 32'h0, lat, rd, err, nwr, base);
        check("mlh_lat", 32'(lat), 32'd3);
        check("mlh_rdata", rd, 32'hFFFF_9234);
        issue(1'b0, 2'b01, 1'b1, 32'h41, 32'h0, lat, rd, err, nwr, base);
        check("mlhu_rdata", rd, 32'h0000_9234);

        // Invalid size: no memory access, error response.
        issue(1'b1, 2'b11, 1'b0, 32'h60, 32'hFFFF_FFFF, lat, rd, err, nwr, base);
        check("bad_lat", 32'(lat), 32'd1);
        check("bad_err", 32'(err), 32'd1);
        check("bad_rdata", rd, 32'd0);
        check("bad_nwr", 32'(nwr), 32'd0);

        // Reset during a split store: beats issued so far commit, the rest do not.
        @(negedge clock);
        base = wr_count;
        seen = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h51; req_wdata = 32'hAABB_CCDD;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        if (resp_valid) seen = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_ready", 32'(req_ready), 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (resp_valid) seen = 1'b1;
        end
        check("abort_no_resp", 32'(seen), 32'd0);
        check("abort_nwr", 32'(wr_count - base), 32'd2);
        check("abort_m51", 32'(mem[8'h51]), 32'hDD);
        check("abort_m52", 32'(mem[8'h52]), 32'hCC);
        check("abort_m53", 32'(mem[8'h53]), 32'h00);
        check("abort_m54", 32'(mem[8'h54]), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
